sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_deb_pkg.sv | 26 ++
 rtl/sw_deb_ch.sv | 131 +++++++++++++
 rtl/sw_debounce.sv | 46 ++++
 tb/tb_sw_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sw_deb_pkg.sv
// ---------------------------------------------------------------------------
// sw_deb_pkg
// Shared definitions for the switch debouncer.
//   deb_state_t      : per-channel FSM state encoding (2 bits, four states)
//   DEB_CNT_DEFAULT  : default stability window in CLK cycles (10 ms @ 125 MHz)
//   state_level()    : debounced level implied by a given FSM state
// Optional feature macro used by the importing files: SW_DEB_EDGE_PULSE_EN
// ---------------------------------------------------------------------------
package sw_deb_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } deb_state_t;

   localparam int DEB_CNT_DEFAULT = 1250000;

   // A channel reports 1 while it is settled high or still checking a
   // possible fall; the output only moves once a window completes.
   function automatic logic state_level(input deb_state_t s);
      return (s == STABLE_HI) || (s == CHK_LO);
   endfunction

endpackage

// File: rtl/sw_deb_ch.sv
// ---------------------------------------------------------------------------
// sw_deb_ch
// One debounced switch channel: two-flop synchronizer, 4-state window FSM
// and window counter.
// Ports:
//   CLK      in  system clock, rising edge
//   RST_N    in  asynchronous active-low reset
//   SW_IN    in  raw bouncing switch level
//   SW_OUT   out registered debounced level
//   SW_RISE  out one-cycle pulse on debounced 0->1 (0 unless pulses enabled)
//   SW_FALL  out one-cycle pulse on debounced 1->0 (0 unless pulses enabled)
// Macro SW_DEB_EDGE_PULSE_EN: when defined, builds the edge pulse registers.
// ---------------------------------------------------------------------------
module sw_deb_ch
   import sw_deb_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic SW_IN,
   output logic SW_OUT,
   output logic SW_RISE,
   output logic SW_FALL
);

   localparam int              CW       = $clog2(DEB_CNT) + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CNT - 1);

   logic            sync1_reg;
   logic            sync2_reg;
   deb_state_t      state_reg;
   logic [CW-1:0]   cnt_reg;
   logic            out_reg;

   // Raw input is asynchronous; only sync2_reg is used downstream.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= SW_IN;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef SW_DEB_EDGE_PULSE_EN
   logic rise_reg;
   logic fall_reg;
`endif

   // Window FSM. The counter is cleared on every entry to and exit from a
   // CHK state, so it never needs to count past DEB_CNT-1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg <= STABLE_LO;
         cnt_reg   <= '0;
         out_reg   <= 1'b0;
`ifdef SW_DEB_EDGE_PULSE_EN
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
`endif
      end else begin
`ifdef SW_DEB_EDGE_PULSE_EN
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
`endif
         case (state_reg)
            STABLE_LO: begin
               if (sync2_reg) begin
                  state_reg <= CHK_HI;
                  cnt_reg   <= '0;
               end
            end
            CHK_HI: begin
               if (!sync2_reg) begin
                  // bounce: abandon the window, level unchanged
                  state_reg <= STABLE_LO;
                  cnt_reg   <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= STABLE_HI;
                  cnt_reg   <= '0;
                  out_reg   <= 1'b1;
`ifdef SW_DEB_EDGE_PULSE_EN
                  rise_reg  <= 1'b1;
`endif
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            STABLE_HI: begin
               if (!sync2_reg) begin
                  state_reg <= CHK_LO;
                  cnt_reg   <= '0;
               end
            end
            CHK_LO: begin
               if (sync2_reg) begin
                  state_reg <= STABLE_HI;
                  cnt_reg   <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= STABLE_LO;
                  cnt_reg   <= '0;
                  out_reg   <= 1'b0;
`ifdef SW_DEB_EDGE_PULSE_EN
                  fall_reg  <= 1'b1;
`endif
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= STABLE_LO;
               cnt_reg   <= '0;
               out_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign SW_OUT = out_reg;

`ifdef SW_DEB_EDGE_PULSE_EN
   assign SW_RISE = rise_reg;
   assign SW_FALL = fall_reg;
`else
   assign SW_RISE = 1'b0;
   assign SW_FALL = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// N_CH independent switch debouncers (ch0 = counter reset, ch1 = count
// direction in the default configuration).
// Parameters:
//   N_CH     number of channels, 1..8
//   DEB_CNT  stability window in CLK cycles, 1..2^24
// Ports:
//   CLK      in  125 MHz system clock, rising edge
//   RST_N    in  asynchronous active-low reset
//   SW_IN    in  [N_CH] raw bouncing switch levels
//   SW_OUT   out [N_CH] registered debounced levels
//   SW_RISE  out [N_CH] one-cycle pulses on debounced 0->1
//   SW_FALL  out [N_CH] one-cycle pulses on debounced 1->0
// Macro SW_DEB_EDGE_PULSE_EN: when undefined SW_RISE/SW_FALL are tied to 0.
// ---------------------------------------------------------------------------
module sw_debounce
   import sw_deb_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N_CH-1:0] SW_IN,
   output logic [N_CH-1:0] SW_OUT,
   output logic [N_CH-1:0] SW_RISE,
   output logic [N_CH-1:0] SW_FALL
);

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         sw_deb_ch #(
            .DEB_CNT (DEB_CNT)
         ) u_ch (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .SW_IN   (SW_IN[gi]),
            .SW_OUT  (SW_OUT[gi]),
            .SW_RISE (SW_RISE[gi]),
            .SW_FALL (SW_FALL[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
// Directed stimulus for sw_debounce (N_CH=2, DEB_CNT=4). Each stimulus step
// queues the output event it should cause (edge number, SW_OUT, SW_RISE,
// SW_FALL); a monitor on the falling edge pops and compares an entry
// whenever SW_OUT changes or a pulse is present.
// Edge numbering: cyc counts rising CLK edges; an input driven on a falling
// edge is first sampled at edge cyc+1, and the output moves 6 edges later.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

   localparam int N_CH    = 2;
   localparam int DEB_CNT = 4;

`ifdef SW_DEB_EDGE_PULSE_EN
   localparam logic PEN = 1'b1;
`else
   localparam logic PEN = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [1:0] out;
      logic [1:0] rise;
      logic [1:0] fall;
   } exp_t;

   logic            CLK;
   logic            RST_N;
   logic [N_CH-1:0] SW_IN;
   logic [N_CH-1:0] SW_OUT;
   logic [N_CH-1:0] SW_RISE;
   logic [N_CH-1:0] SW_FALL;

   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t exp_q[$];

   sw_debounce #(
      .N_CH    (N_CH),
      .DEB_CNT (DEB_CNT)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .SW_IN   (SW_IN),
      .SW_OUT  (SW_OUT),
      .SW_RISE (SW_RISE),
      .SW_FALL (SW_FALL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [1:0] pmask(input logic [1:0] v);
      return v & {2{PEN}};
   endfunction

   task automatic push(input int c, input logic [1:0] o, input logic [1:0] r,
                       input logic [1:0] f);
      exp_t e;
      e.cyc  = c;
      e.out  = o;
      e.rise = pmask(r);
      e.fall = pmask(f);
      exp_q.push_back(e);
   endtask

   // drive a new input level on a falling edge; returns the sampling edge
   task automatic drive(input logic [1:0] v, output int s);
      @(negedge CLK);
      SW_IN = v;
      s = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check_now(input string name, input logic [1:0] act,
                            input logic [1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, req, $time);
      end else begin
         $display("ok   %s: %b", name, act);
      end
   endtask

   // monitor / scoreboard
   initial begin
      logic [1:0] prev;
      exp_t       e;
      prev = 2'b00;
      forever begin
         @(negedge CLK);
         if ((SW_OUT !== prev) || (SW_RISE !== 2'b00) || (SW_FALL !== 2'b00)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event: edge %0d out=%b rise=%b fall=%b, required none",
                        cyc, SW_OUT, SW_RISE, SW_FALL);
            end else begin
               e = exp_q.pop_front();
               if ((e.cyc != cyc) || (e.out !== SW_OUT) || (e.rise !== SW_RISE) ||
                   (e.fall !== SW_FALL)) begin
                  n_bad++;
                  $display("FAIL event: got edge %0d out=%b rise=%b fall=%b, required edge %0d out=%b rise=%b fall=%b",
                           cyc, SW_OUT, SW_RISE, SW_FALL, e.cyc, e.out, e.rise, e.fall);
               end else begin
                  $display("ok   event: edge %0d out=%b rise=%b fall=%b",
                           cyc, SW_OUT, SW_RISE, SW_FALL);
               end
            end
            prev = SW_OUT;
         end
      end
   end

   initial begin
      int s;
      int k;
      n_cmp = 0;
      n_bad = 0;
      RST_N = 1'b0;
      SW_IN = 2'b00;

      #3;
      check_now("reset_out",  SW_OUT,  2'b00);
      check_now("reset_rise", SW_RISE, 2'b00);
      check_now("reset_fall", SW_FALL, 2'b00);
      idle(3);
      RST_N = 1'b1;
      idle(3);

      // clean rise then fall on ch0
      drive(2'b01, s); push(s + 6, 2'b01, 2'b01, 2'b00); idle(12);
      drive(2'b00, s); push(s + 6, 2'b00, 2'b00, 2'b01); idle(12);

      // bounce: high 2 samples, low 1, then high
      drive(2'b01, s);
      idle(1);
      drive(2'b00, s);
      drive(2'b01, s); push(s + 6, 2'b01, 2'b01, 2'b00); idle(12);
      drive(2'b00, s); push(s + 6, 2'b00, 2'b00, 2'b01); idle(12);

      // simultaneous transitions on both channels
      drive(2'b11, s); push(s + 6, 2'b11, 2'b11, 2'b00); idle(12);
      drive(2'b00, s); push(s + 6, 2'b00, 2'b00, 2'b11); idle(12);

      // ch1 settled high, ch0 mid-window when reset hits between edges
      drive(2'b10, s); push(s + 6, 2'b10, 2'b10, 2'b00); idle(12);
      drive(2'b11, s);
      repeat (3) @(posedge CLK);   // edge s+2: ch0 enters CHK_HI
      #2;
      push(cyc, 2'b00, 2'b00, 2'b00);
      RST_N = 1'b0;
      #1;
      check_now("async_rst_out",  SW_OUT,  2'b00);
      check_now("async_rst_rise", SW_RISE, 2'b00);
      check_now("async_rst_fall", SW_FALL, 2'b00);
      SW_IN = 2'b00;
      idle(3);
      RST_N = 1'b1;
      idle(15);                    // nothing expected

      // switches held high through reset release
      @(negedge CLK);
      RST_N = 1'b0;
      SW_IN = 2'b11;
      idle(2);
      RST_N = 1'b1;
      k = cyc;
      push(k + 7, 2'b11, 2'b11, 2'b00);
      idle(12);
      drive(2'b00, s); push(s + 6, 2'b00, 2'b00, 2'b11); idle(12);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events: %0d events never seen, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
